regfile_banked: RTL

Parametrised successor to the team's single-port 16x64 register memory, used as scratch/state storage inside the puzzle datapath. Provides one byte-enabled write port and two independent registered read ports, with write-first forwarding. Adds a multi-cycle background clear engine so software can wipe the array without asserting reset. Reset still clears the whole array in one cycle.

---
 rtl/regfile_banked.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/regfile_banked.sv
// regfile_banked
// Banked scratch/state register array for the puzzle datapath: DEPTH words of
// DATA_W bits, one byte-enabled write port, two independent registered read
// ports with write-first forwarding, and a background clear engine that wipes
// one entry per cycle without needing a reset.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset; clears array, read data and engine
//   we         write request
//   wr_addr    write address (addresses >= DEPTH are dropped)
//   wr_data    write data
//   wr_be      byte enables, bit i covers wr_data[8i+7:8i]
//   wr_ready   combinational: a write presented this cycle is accepted
//   rd_en_a    read enable, port A
//   rd_addr_a  read address, port A
//   rd_data_a  registered read data, port A (holds when rd_en_a=0)
//   rd_en_b    read enable, port B
//   rd_addr_b  read address, port B
//   rd_data_b  registered read data, port B (holds when rd_en_b=0)
//   clr_start  single-cycle pulse that starts a background clear
//   clr_busy   clear sweep in progress (exactly DEPTH cycles)
//   clr_done   one-cycle pulse in the cycle after the last entry is cleared
module regfile_banked #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 16,
  parameter  int ADDR_W = 4,
  localparam int NBYTE  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NBYTE-1:0]  wr_be,
  output logic              wr_ready,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_next_s;
  logic              done_r;
  logic              done_next_s;
  logic              sweep_s;
  logic              last_s;
  logic              wr_ok_s;
  logic [DATA_W-1:0] wr_word_s;
  logic [DATA_W-1:0] rd_a_r;
  logic [DATA_W-1:0] rd_b_r;
  logic [DATA_W-1:0] rd_next_a_s;
  logic [DATA_W-1:0] rd_next_b_s;

  // Old word with the enabled byte lanes replaced by the new data.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NBYTE-1:0]  be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // DEPTH need not be a power of two, so the top of the address space can be unmapped.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  assign sweep_s   = (state_r == SWEEP);
  assign last_s    = (32'(cnt_r) == (DEPTH - 1));
  // A clear request takes priority over a simultaneous write.
  assign wr_ready  = rst_n & ~sweep_s & ~clr_start;
  assign wr_ok_s   = we & wr_ready & in_range(wr_addr);
  assign wr_word_s = merge_bytes(mem_r[wr_addr], wr_data, wr_be);

  // Clear engine next-state: one entry per cycle from 0 to DEPTH-1.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    done_next_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (clr_start) begin
          state_next_s = SWEEP;
          cnt_next_s   = {ADDR_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      SWEEP: begin
        if (last_s) begin
          state_next_s = IDLE;
          cnt_next_s   = {ADDR_W{1'b0}};
          done_next_s  = 1'b1;
        end else begin
          cnt_next_s   = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // Clear engine state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      done_r  <= done_next_s;
    end
  end

  // Storage array: reset wipes everything, the sweep clears one entry, else accepted writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end else if (sweep_s && (32'(cnt_r) == i)) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end else if (wr_ok_s && (32'(wr_addr) == i)) begin
        mem_r[i] <= wr_word_s;
      end
    end
  end

  // Port A next data: the word as it will be after this edge (clear/write forwarded).
  always_comb begin
    rd_next_a_s = rd_a_r;
    if (rd_en_a) begin
      if (!in_range(rd_addr_a)) begin
        rd_next_a_s = {DATA_W{1'b0}};
      end else if (sweep_s && (rd_addr_a == cnt_r)) begin
        rd_next_a_s = {DATA_W{1'b0}};
      end else if (wr_ok_s && (rd_addr_a == wr_addr)) begin
        rd_next_a_s = wr_word_s;
      end else begin
        rd_next_a_s = mem_r[rd_addr_a];
      end
    end else begin
      rd_next_a_s = rd_a_r;
    end
  end

  // Port B next data, forwarded independently of port A.
  always_comb begin
    rd_next_b_s = rd_b_r;
    if (rd_en_b) begin
      if (!in_range(rd_addr_b)) begin
        rd_next_b_s = {DATA_W{1'b0}};
      end else if (sweep_s && (rd_addr_b == cnt_r)) begin
        rd_next_b_s = {DATA_W{1'b0}};
      end else if (wr_ok_s && (rd_addr_b == wr_addr)) begin
        rd_next_b_s = wr_word_s;
      end else begin
        rd_next_b_s = mem_r[rd_addr_b];
      end
    end else begin
      rd_next_b_s = rd_b_r;
    end
  end

  // Read data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_a_r <= {DATA_W{1'b0}};
      rd_b_r <= {DATA_W{1'b0}};
    end else begin
      rd_a_r <= rd_next_a_s;
      rd_b_r <= rd_next_b_s;
    end
  end

  assign rd_data_a = rd_a_r;
  assign rd_data_b = rd_b_r;
  assign clr_busy  = sweep_s;
  assign clr_done  = done_r;

endmodule
